// File: rtl/ret_addr_stack_if.sv
// Bus bundle for ret_addr_stack: command/data inputs (master drives) and stack status (slave drives).
interface ret_addr_stack_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] top_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, flush, clr_err, push_data,
    input  top_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clr_err, push_data,
    output top_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address stack with sticky overflow/underflow flags.
// Define RAS_OVF_WRAP_EN to make a push when full overwrite the oldest entry instead of dropping.
module ret_addr_stack #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 8
) (
  input logic               clk,
  input logic               reset,
  ret_addr_stack_if.slave   ras_io
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic              is_empty, is_full;
  logic              ovf_set, unf_set;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCnt);

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = tp_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ras_io.flush) begin
      count_d = '0;
    end else if (ras_io.push && ras_io.pop && !is_empty) begin
      wr_en  = 1'b1;
      wr_idx = tp_q;
    end else if (ras_io.push && !is_full) begin
      // Also covers push+pop on an empty stack.
      wr_en   = 1'b1;
      wr_idx  = tp_q + PTR_W'(1);
      tp_d    = tp_q + PTR_W'(1);
      count_d = count_q + CNT_W'(1);
    end else if (ras_io.push && !ras_io.pop) begin
      ovf_set = 1'b1;
`ifdef RAS_OVF_WRAP_EN
      // When full, slot tp+1 holds the oldest entry.
      wr_en  = 1'b1;
      wr_idx = tp_q + PTR_W'(1);
      tp_d   = tp_q + PTR_W'(1);
`endif
    end else if (ras_io.pop && !ras_io.push) begin
      if (is_empty) begin
        unf_set = 1'b1;
      end else begin
        tp_d    = tp_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
    end
    ovf_d = (ovf_q & ~ras_io.clr_err) | ovf_set;
    unf_d = (unf_q & ~ras_io.clr_err) | unf_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tp_q    <= '1;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; it is never visible while the stack is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= ras_io.push_data;
    end
  end

  assign ras_io.top_data  = is_empty ? '0 : mem_q[tp_q];
  assign ras_io.count     = count_q;
  assign ras_io.empty     = is_empty;
  assign ras_io.full      = is_full;
  assign ras_io.overflow  = ovf_q;
  assign ras_io.underflow = unf_q;
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack: vector table plus overflow and async-reset sequences.
module tb_ret_addr_stack;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ret_addr_stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  ret_addr_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .ras_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        psh;
    logic        pp;
    logic        fl;
    logic        clr;
    logic [11:0] d;
    int          cnt;
    logic [11:0] top;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int cnt, input int top, input logic emp,
                         input logic ful, input logic ovf, input logic unf);
    chk({name, ".count"}, int'(bus.count), cnt);
    chk({name, ".top"}, int'(bus.top_data), top);
    chk({name, ".empty"}, int'(bus.empty), int'(emp));
    chk({name, ".full"}, int'(bus.full), int'(ful));
    chk({name, ".ovf"}, int'(bus.overflow), int'(ovf));
    chk({name, ".unf"}, int'(bus.underflow), int'(unf));
  endtask

  task automatic drive(input logic psh, input logic pp, input logic fl, input logic clr,
                       input logic [11:0] d);
    bus.push      = psh;
    bus.pop       = pp;
    bus.flush     = fl;
    bus.clr_err   = clr;
    bus.push_data = d;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic add(input string n, input logic psh, input logic pp, input logic fl,
                     input logic clr, input logic [11:0] d, input int cnt, input logic [11:0] top,
                     input logic emp, input logic ful, input logic ovf, input logic unf);
    vec_t v;
    v = '{n, psh, pp, fl, clr, d, cnt, top, emp, ful, ovf, unf};
    vecs.push_back(v);
  endtask

  initial begin
    int exp_top;
    total = 0;
    bad   = 0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    bus.push_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    //  name          psh pp fl clr data    cnt top    emp ful ovf unf
    add("pop_empty",   0, 1, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 1);
    add("clr_unf",     0, 0, 0, 1, 12'h000, 0, 12'h000, 1, 0, 0, 0);
    add("push100",     1, 0, 0, 0, 12'h100, 1, 12'h100, 0, 0, 0, 0);
    add("push200",     1, 0, 0, 0, 12'h200, 2, 12'h200, 0, 0, 0, 0);
    add("push300",     1, 0, 0, 0, 12'h300, 3, 12'h300, 0, 0, 0, 0);
    add("pop_a",       0, 1, 0, 0, 12'h000, 2, 12'h200, 0, 0, 0, 0);
    add("pop_b",       0, 1, 0, 0, 12'h000, 1, 12'h100, 0, 0, 0, 0);
    add("pushAA",      1, 0, 0, 0, 12'h0AA, 2, 12'h0AA, 0, 0, 0, 0);
    add("replBB",      1, 1, 0, 0, 12'h0BB, 2, 12'h0BB, 0, 0, 0, 0);
    add("pop_c",       0, 1, 0, 0, 12'h000, 1, 12'h100, 0, 0, 0, 0);
    add("pop_d",       0, 1, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
    add("pp_emptyCC",  1, 1, 0, 0, 12'h0CC, 1, 12'h0CC, 0, 0, 0, 0);
    add("push111",     1, 0, 0, 0, 12'h111, 2, 12'h111, 0, 0, 0, 0);
    add("push222",     1, 0, 0, 0, 12'h222, 3, 12'h222, 0, 0, 0, 0);
    add("push333",     1, 0, 0, 0, 12'h333, 4, 12'h333, 0, 0, 0, 0);
    add("push444",     1, 0, 0, 0, 12'h444, 5, 12'h444, 0, 0, 0, 0);
    add("flush_push",  1, 0, 1, 0, 12'h123, 0, 12'h000, 1, 0, 0, 0);
    add("pop_empty2",  0, 1, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 1);
    add("flush_keep",  0, 0, 1, 0, 12'h000, 0, 12'h000, 1, 0, 0, 1);
    add("clr_vs_err",  0, 1, 0, 1, 12'h000, 0, 12'h000, 1, 0, 0, 1);
    add("clr_unf2",    0, 0, 0, 1, 12'h000, 0, 12'h000, 1, 0, 0, 0);
    add("push_after",  1, 0, 0, 0, 12'h5A5, 1, 12'h5A5, 0, 0, 0, 0);
    add("flush_pop",   0, 1, 1, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].psh, vecs[i].pp, vecs[i].fl, vecs[i].clr, vecs[i].d);
      chk_all(vecs[i].name, vecs[i].cnt, int'(vecs[i].top), vecs[i].emp, vecs[i].ful,
              vecs[i].ovf, vecs[i].unf);
    end

    // Fill past full with 0x001..0x009.
    for (int i = 1; i <= 9; i++) begin
`ifdef RAS_OVF_WRAP_EN
      exp_top = i;
`else
      exp_top = (i > 8) ? 8 : i;
`endif
      drive(1'b1, 1'b0, 1'b0, 1'b0, 12'(i));
      chk_all($sformatf("fill%0d", i), (i > 8) ? 8 : i, exp_top, 1'b0, i >= 8, i == 9, 1'b0);
    end

    // Push+pop while full replaces top without overflow after clearing.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    chk("ovf_cleared", int'(bus.overflow), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h7E7);
    chk_all("pp_full", 8, 12'h7E7, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);

    // Remaining 7 pops walk down from the entry below the replaced top.
    for (int k = 1; k < 8; k++) begin
`ifdef RAS_OVF_WRAP_EN
      exp_top = 9 - k;
`else
      exp_top = 8 - k;
`endif
      chk($sformatf("drain%0d.top", k), int'(bus.top_data), exp_top);
      chk($sformatf("drain%0d.count", k), int'(bus.count), 8 - k);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    end
    chk_all("drained", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset mid-cycle with count=4.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0A0 + 12'(i));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0AF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    chk_all("pre_async", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0B0 + 12'(i));
    chk_all("count4", 4, 12'h0B3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.push = 1'b1;
    bus.push_data = 12'h0EE;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold.count", int'(bus.count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.push_data = 12'h055;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    chk_all("first_edge", 1, 12'h055, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
